// File: rtl/axi4_stream_pkt_limiter_if.sv
// AXI4-Stream interface bundle used by axi4_stream_pkt_limiter.
// Signals: tvalid, tready, tdata, tstrb, tkeep, tlast, tuser, tdest, tid.
// master drives payload and tvalid and samples tready; slave does the reverse.
interface axi4_stream_if #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_limiter.sv
// axi4_stream_pkt_limiter: caps every AXI4-Stream packet at MAX_WORDS beats.
// The MAX_WORDS-th beat of a longer packet is forwarded with tlast forced high
// and the rest of that packet is consumed without being forwarded.
// One registered output stage, 1 beat/cycle throughput.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   pkt_i        input stream (slave)
//   pkt_o        limited output stream (master)
//   trunc_o      1-cycle pulse (registered) after a truncating beat is accepted
//   trunc_cnt_o  saturating count of truncated packets
//   busy_o       high while mid-packet (PASS or DISCARD)
module axi4_stream_pkt_limiter #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned MAX_WORDS   = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  axi4_stream_if.slave         pkt_i,
  axi4_stream_if.master        pkt_o,
  output logic                 trunc_o,
  output logic [CNT_WIDTH-1:0] trunc_cnt_o,
  output logic                 busy_o
);

  localparam int unsigned WCNT_W = $clog2(MAX_WORDS) + 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, PASS, DISCARD} state_e;

  state_e                   state_q, state_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic                     trunc_q, trunc_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic                     out_valid_q;
  logic [TDATA_WIDTH-1:0]   tdata_q;
  logic [TDATA_WIDTH/8-1:0] tstrb_q;
  logic [TDATA_WIDTH/8-1:0] tkeep_q;
  logic                     tlast_q;
  logic [TUSER_WIDTH-1:0]   tuser_q;
  logic [TDEST_WIDTH-1:0]   tdest_q;
  logic [TID_WIDTH-1:0]     tid_q;

  logic in_ready;
  logic acc;
  logic load;
  logic cut;

  // In DISCARD nothing is loaded, so input may be drained regardless of the
  // output register.
  assign in_ready = (state_q == DISCARD) ? 1'b1 : (!out_valid_q || pkt_o.tready);
  assign acc      = pkt_i.tvalid && in_ready;
  assign load     = acc && (state_q != DISCARD);
  assign cut      = !pkt_i.tlast && (wcnt_q == WCNT_LAST);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    trunc_d = 1'b0;
    cnt_d   = cnt_q;
    if (acc) begin
      unique case (state_q)
        IDLE, PASS: begin
          if (pkt_i.tlast) begin
            wcnt_d  = '0;
            state_d = IDLE;
          end else if (cut) begin
            wcnt_d  = '0;
            trunc_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            state_d = DISCARD;
          end else begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = PASS;
          end
        end
        DISCARD: begin
          if (pkt_i.tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      trunc_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      trunc_q <= trunc_d;
      cnt_q   <= cnt_d;
      if (load)              out_valid_q <= 1'b1;
      else if (pkt_o.tready) out_valid_q <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while out_valid_q is high.
  always_ff @(posedge clk_i) begin
    if (load) begin
      tdata_q <= pkt_i.tdata;
      tstrb_q <= pkt_i.tstrb;
      tkeep_q <= pkt_i.tkeep;
      tlast_q <= pkt_i.tlast || cut;
      tuser_q <= pkt_i.tuser;
      tdest_q <= pkt_i.tdest;
      tid_q   <= pkt_i.tid;
    end
  end

  assign pkt_i.tready = in_ready;
  assign pkt_o.tvalid = out_valid_q;
  assign pkt_o.tdata  = tdata_q;
  assign pkt_o.tstrb  = tstrb_q;
  assign pkt_o.tkeep  = tkeep_q;
  assign pkt_o.tlast  = tlast_q;
  assign pkt_o.tuser  = tuser_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tid    = tid_q;

  assign trunc_o     = trunc_q;
  assign trunc_cnt_o = cnt_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_axi4_stream_pkt_limiter.sv
module tb_axi4_stream_pkt_limiter;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trunc_o;
  logic [15:0] trunc_cnt_o;
  logic        busy_o;

  int asserts = 0;
  int fails   = 0;

  axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) in_if ();
  axi4_stream_if #(.TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1)) out_if ();

  axi4_stream_pkt_limiter #(
    .TDATA_WIDTH(32), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .TID_WIDTH(1),
    .MAX_WORDS(MAXW), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .pkt_i(in_if), .pkt_o(out_if),
    .trunc_o(trunc_o), .trunc_cnt_o(trunc_cnt_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // scoreboard item: {tdata, tstrb, tkeep, tlast, tuser, tdest, tid}
  logic [43:0] q[$];
  int m_cnt = 0;
  bit m_disc = 0;
  int trunc_seen = 0;

  // Inputs change only at posedge+1, so values seen at negedge are those
  // the next posedge will act on.
  always @(negedge clk) begin
    logic [43:0] exp_v, obs_v;
    logic        l;
    if (rst) begin
      q.delete(); m_cnt = 0; m_disc = 0; trunc_seen = 0;
    end else begin
      if (trunc_o) trunc_seen++;
      if (out_if.tvalid && out_if.tready) begin
        obs_v = {out_if.tdata, out_if.tstrb, out_if.tkeep, out_if.tlast,
                 out_if.tuser, out_if.tdest, out_if.tid};
        asserts++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_extra_beat: got %h, expected no beat", obs_v);
        end else begin
          exp_v = q.pop_front();
          if (obs_v !== exp_v) begin
            fails++;
            $display("FAIL sb_beat: got %h, expected %h", obs_v, exp_v);
          end
        end
      end
      if (in_if.tvalid && in_if.tready) begin
        if (m_disc) begin
          if (in_if.tlast) m_disc = 0;
        end else begin
          l = in_if.tlast;
          if (in_if.tlast) m_cnt = 0;
          else if (m_cnt == MAXW - 1) begin l = 1'b1; m_cnt = 0; m_disc = 1; end
          else m_cnt++;
          q.push_back({in_if.tdata, in_if.tstrb, in_if.tkeep, l,
                       in_if.tuser, in_if.tdest, in_if.tid});
        end
      end
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic l, output int waits);
    waits = 0;
    in_if.tvalid = 1'b1; in_if.tdata = d; in_if.tlast = l;
    in_if.tstrb = d[3:0]; in_if.tkeep = d[7:4];
    in_if.tuser = d[8]; in_if.tdest = d[9]; in_if.tid = d[10];
    forever begin
      @(negedge clk);
      if (in_if.tready) break;
      waits++;
      if (waits > 500) begin
        asserts++; fails++;
        $display("FAIL drive_timeout: tready stuck 0, expected 1 within 500 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_if.tvalid) break;
    end
    asserts++;
    if (q.size() != 0 || out_if.tvalid !== 1'b0) begin
      fails++;
      $display("FAIL drain: %0d beats pending, tvalid=%b; expected 0 and 0", q.size(), out_if.tvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    out_if.tready = 1'b1;
    do_reset();
    @(negedge clk);
    asserts++;
    if ({out_if.tvalid, trunc_o, busy_o, in_if.tready} !== 4'b0001 || trunc_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL reset: tvalid/trunc/busy/in_ready=%b cnt=%0d, expected 0001 cnt=0",
               {out_if.tvalid, trunc_o, busy_o, in_if.tready}, trunc_cnt_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_short_pkt();
    int w;
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 32'h1000_0000 + 32'(i);
      drive_beat(d, i == 2, w);
      asserts++;
      if (out_if.tvalid !== 1'b1 || out_if.tdata !== d || out_if.tlast !== (i == 2) || trunc_o !== 1'b0) begin
        fails++;
        $display("FAIL short_latency: beat%0d v=%b d=%h l=%b tr=%b, expected v=1 d=%h l=%b tr=0",
                 i, out_if.tvalid, out_if.tdata, out_if.tlast, trunc_o, d, i == 2);
      end
    end
    drain();
    asserts++;
    if (trunc_seen != 0) begin
      fails++; $display("FAIL short_trunc: pulses=%0d, expected 0", trunc_seen);
    end
  endtask

  task automatic test_exact_len();
    int w;
    for (int i = 0; i < MAXW; i++) drive_beat(32'h2000_0000 + 32'(i), i == MAXW - 1, w);
    drain();
    asserts++;
    if (trunc_cnt_o !== 16'd0 || trunc_seen != 0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL exact_len: cnt=%0d pulses=%0d busy=%b, expected 0 0 0", trunc_cnt_o, trunc_seen, busy_o);
    end
  endtask

  task automatic test_truncate();
    int w;
    for (int i = 0; i < 4; i++) drive_beat(32'hA000_0000 + 32'(i), 1'b0, w);
    asserts++;
    if (trunc_o !== 1'b1 || out_if.tlast !== 1'b1 || out_if.tdata !== 32'hA000_0003 ||
        busy_o !== 1'b1 || trunc_cnt_o !== 16'd1) begin
      fails++;
      $display("FAIL trunc_point: tr=%b l=%b d=%h busy=%b cnt=%0d, expected 1 1 a0000003 1 1",
               trunc_o, out_if.tlast, out_if.tdata, busy_o, trunc_cnt_o);
    end
    out_if.tready = 1'b0;
    for (int i = 4; i < 7; i++) begin
      drive_beat(32'hA000_0000 + 32'(i), i == 6, w);
      asserts++;
      if (w != 0 || trunc_o !== 1'b0) begin
        fails++;
        $display("FAIL discard_ready: beat%0d waits=%0d tr=%b, expected 0 0", i, w, trunc_o);
      end
    end
    out_if.tready = 1'b1;
    drive_beat(32'hB000_0000, 1'b0, w);
    drive_beat(32'hB000_0001, 1'b1, w);
    drain();
    asserts++;
    if (trunc_cnt_o !== 16'd1 || trunc_seen != 1) begin
      fails++;
      $display("FAIL trunc_count: cnt=%0d pulses=%0d, expected 1 1", trunc_cnt_o, trunc_seen);
    end
  endtask

  task automatic test_backpressure();
    int w;
    drive_beat(32'hC000_0000, 1'b0, w);
    out_if.tready = 1'b0;
    in_if.tvalid = 1'b1; in_if.tdata = 32'hC000_0001; in_if.tlast = 1'b0;
    in_if.tstrb = 4'h1; in_if.tkeep = 4'h0; in_if.tuser = 1'b0; in_if.tdest = 1'b0; in_if.tid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      asserts++;
      if (in_if.tready !== 1'b0 || out_if.tvalid !== 1'b1 || out_if.tdata !== 32'hC000_0000) begin
        fails++;
        $display("FAIL hold: cyc%0d in_rdy=%b v=%b d=%h, expected 0 1 c0000000",
                 i, in_if.tready, out_if.tvalid, out_if.tdata);
      end
      @(posedge clk); #1;
    end
    out_if.tready = 1'b1;
    drive_beat(32'hC000_0001, 1'b0, w);
    drive_beat(32'hC000_0002, 1'b1, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w, len, n_long;
    bit done;
    do_reset();
    n_long = 0; done = 0;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          len = $urandom_range(1, 9);
          if (len > MAXW) n_long++;
          for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            #0;
            drive_beat({p[19:0], b[3:0], 8'($urandom)}, b == len - 1, w);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_if.tready = ($urandom_range(0, 3) != 0);
        end
        out_if.tready = 1'b1;
      end
    join
    drain();
    asserts++;
    if (trunc_cnt_o !== 16'(n_long) || trunc_seen != n_long) begin
      fails++;
      $display("FAIL random_trunc: cnt=%0d pulses=%0d, expected %0d", trunc_cnt_o, trunc_seen, n_long);
    end
  endtask

  task automatic test_reset_discard();
    int w;
    for (int i = 0; i < 6; i++) drive_beat(32'hD000_0000 + 32'(i), 1'b0, w);
    asserts++;
    if (busy_o !== 1'b1 || trunc_cnt_o === 16'd0) begin
      fails++; $display("FAIL pre_reset: busy=%b cnt=%0d, expected busy=1 cnt>0", busy_o, trunc_cnt_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    asserts++;
    if ({out_if.tvalid, trunc_o, busy_o} !== 3'b000 || trunc_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL mid_reset: v/tr/busy=%b cnt=%0d, expected 000 0", {out_if.tvalid, trunc_o, busy_o}, trunc_cnt_o);
    end
    rst = 1'b0;
    drive_beat(32'hE000_0000, 1'b0, w);
    drive_beat(32'hE000_0001, 1'b1, w);
    drain();
    asserts++;
    if (trunc_cnt_o !== 16'd0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL post_reset: cnt=%0d busy=%b, expected 0 0", trunc_cnt_o, busy_o);
    end
  endtask

  initial begin
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tstrb = '0; in_if.tkeep = '0;
    in_if.tlast = 1'b0; in_if.tuser = '0; in_if.tdest = '0; in_if.tid = '0;
    out_if.tready = 1'b1;
    test_reset();
    test_short_pkt();
    test_exact_len();
    test_truncate();
    test_backpressure();
    test_back_to_back();
    test_reset_discard();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
